// File: rtl/stream_upsizer.sv
// Narrow-to-wide stream packer: collects RATIO narrow words little-endian into one wide word,
// with flush of partial groups and synchronous clear.
module stream_upsizer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RATIO      = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_WIDTH*RATIO-1:0]   out_data,
  output logic [RATIO-1:0]              out_keep,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic                          flush,
  input  logic                          clear,
  output logic [$clog2(RATIO):0]        fill
);

  localparam int unsigned FW = $clog2(RATIO) + 1;
  localparam int unsigned OW = DATA_WIDTH * RATIO;

  logic [OW-1:0]    acc_data_q, acc_data_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [OW-1:0]    out_data_q, out_data_d;
  logic [RATIO-1:0] out_keep_q, out_keep_d;
  logic             out_valid_q, out_valid_d;
  logic             flush_pend_q, flush_pend_d;

  logic [OW-1:0]    acc_w;
  logic [FW-1:0]    fill_w;
  logic [RATIO-1:0] keep_w;
  logic             in_fire;
  logic             out_free;
  logic             flush_req;
  logic             emit;

  // Accumulate, hand off to the output register, and service flush/clear.
  always_comb begin
    acc_data_d   = acc_data_q;
    fill_d       = fill_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_valid_d  = out_valid_q;
    flush_pend_d = flush_pend_q;

    in_ready  = (fill_q < FW'(RATIO)) && !flush_pend_q;
    in_fire   = in_valid && in_ready;
    out_free  = !out_valid_q || out_ready;
    flush_req = flush || flush_pend_q;

    acc_w = acc_data_q;
    for (int k = 0; k < RATIO; k++) begin
      if (in_fire && (fill_q == FW'(k))) acc_w[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
    end
    fill_w = fill_q + FW'(in_fire);

    for (int k = 0; k < RATIO; k++) keep_w[k] = (FW'(k) < fill_w);

    emit = out_free && ((fill_w == FW'(RATIO)) || (flush_req && (fill_w != '0)));

    if (clear) begin
      acc_data_d   = '0;
      fill_d       = '0;
      out_data_d   = '0;
      out_keep_d   = '0;
      out_valid_d  = 1'b0;
      flush_pend_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      acc_data_d = acc_w;
      fill_d     = fill_w;
      // A flush that cannot land now is remembered until the output register frees up.
      if (flush && (fill_w != '0) && !out_free) flush_pend_d = 1'b1;
      if (emit) begin
        out_data_d   = acc_w;
        out_keep_d   = keep_w;
        out_valid_d  = 1'b1;
        acc_data_d   = '0;
        fill_d       = '0;
        flush_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_data_q   <= '0;
      fill_q       <= '0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_valid_q  <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      acc_data_q   <= acc_data_d;
      fill_q       <= fill_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_valid_q  <= out_valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_valid = out_valid_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_stream_upsizer.sv
// Directed bench for stream_upsizer: packing, backpressure, flush, clear, reset, random stream.
module tb_stream_upsizer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready;
  logic        flush;
  logic        clear;
  logic [2:0]  fill;

  int n_checks = 0;
  int n_pass   = 0;

  stream_upsizer #(.DATA_WIDTH(8), .RATIO(4)) dut (
    .clk(clk), .rstn(rstn),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .clear(clear), .fill(fill)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  byte unsigned src[$];
  byte unsigned sb[$];
  logic [31:0]  exp_w;
  int           words;
  bit           in_fire, out_fire;

  initial begin
    rstn = 1'b0; in_data = '0; in_valid = 0; out_ready = 0; flush = 0; clear = 0;
    #12;
    check("rst_fill", 64'(fill), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_keep", 64'(out_keep), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rstn = 1'b1;
    tick();

    // Basic group at full rate
    out_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    check("grp_pre_valid", 64'(out_valid), 64'd0);
    check("grp_pre_fill", 64'(fill), 64'd3);
    push(8'h44);
    check("grp_valid", 64'(out_valid), 64'd1);
    check("grp_data", 64'(out_data), 64'h44332211);
    check("grp_keep", 64'(out_keep), 64'hF);
    check("grp_fill0", 64'(fill), 64'd0);
    tick();
    check("grp_drained", 64'(out_valid), 64'd0);

    // Backpressure: two groups, second held in the accumulator
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    check("bp_data", 64'(out_data), 64'h04030201);
    check("bp_fill", 64'(fill), 64'd4);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    tick(); tick();
    check("bp_stable", 64'(out_data), 64'h04030201);
    check("bp_stable_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    check("bp_second", 64'(out_data), 64'h08070605);
    check("bp_second_valid", 64'(out_valid), 64'd1);
    check("bp_fill0", 64'(fill), 64'd0);
    tick();
    check("bp_drained", 64'(out_valid), 64'd0);

    // Partial flush, then flush with nothing held
    push(8'hAA); push(8'hBB);
    flush = 1'b1; tick(); flush = 1'b0;
    check("fl_data", 64'(out_data), 64'h0000BBAA);
    check("fl_keep", 64'(out_keep), 64'h3);
    check("fl_valid", 64'(out_valid), 64'd1);
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    check("fl_empty_valid", 64'(out_valid), 64'd0);
    tick();
    check("fl_empty_valid2", 64'(out_valid), 64'd0);

    // Flush while the output register is occupied
    out_ready = 1'b0;
    push(8'h10); push(8'h11); push(8'h12); push(8'h13);
    push(8'h20);
    flush = 1'b1; tick(); flush = 1'b0;
    check("fp_in_ready", 64'(in_ready), 64'd0);
    check("fp_fill", 64'(fill), 64'd1);
    check("fp_held", 64'(out_data), 64'h13121110);
    tick();
    check("fp_in_ready2", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    check("fp_part_data", 64'(out_data), 64'h00000020);
    check("fp_part_keep", 64'(out_keep), 64'h1);
    check("fp_part_valid", 64'(out_valid), 64'd1);
    check("fp_in_ready3", 64'(in_ready), 64'd1);
    tick();
    check("fp_drained", 64'(out_valid), 64'd0);

    // Flush coinciding with the last word of a group
    push(8'h31); push(8'h32); push(8'h33);
    flush = 1'b1; push(8'h34); flush = 1'b0;
    check("fl4_data", 64'(out_data), 64'h34333231);
    check("fl4_keep", 64'(out_keep), 64'hF);
    tick();
    check("fl4_no_extra", 64'(out_valid), 64'd0);

    // Clear beats a concurrent narrow word
    out_ready = 1'b0;
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    push(8'h51); push(8'h52); push(8'h53);
    check("clr_pre_fill", 64'(fill), 64'd3);
    clear = 1'b1; in_data = 8'h54; in_valid = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check("clr_fill", 64'(fill), 64'd0);
    check("clr_valid", 64'(out_valid), 64'd0);
    check("clr_keep", 64'(out_keep), 64'd0);
    out_ready = 1'b1;
    push(8'h61); push(8'h62); push(8'h63); push(8'h64);
    check("clr_after", 64'(out_data), 64'h64636261);
    tick();

    // Asynchronous reset mid-group with a word held
    out_ready = 1'b0;
    push(8'h81); push(8'h82); push(8'h83); push(8'h84);
    push(8'h85); push(8'h86);
    #2 rstn = 1'b0;
    #1;
    check("ar_fill", 64'(fill), 64'd0);
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_data", 64'(out_data), 64'd0);
    check("ar_keep", 64'(out_keep), 64'd0);
    check("ar_in_ready", 64'(in_ready), 64'd1);
    #1 rstn = 1'b1;
    tick();
    out_ready = 1'b1;
    push(8'h91); push(8'h92); push(8'h93); push(8'h94);
    check("ar_after", 64'(out_data), 64'h94939291);
    check("ar_after_keep", 64'(out_keep), 64'hF);
    tick();

    // Random stream with random gaps and backpressure
    for (int i = 0; i < 64; i++) begin
      src.push_back(8'($urandom_range(0, 255)));
      sb.push_back(src[i]);
    end
    words = 0;
    for (int cyc = 0; cyc < 4000 && words < 16; cyc++) begin
      in_valid  = (src.size() > 0) && ($urandom_range(0, 3) != 0);
      in_data   = (src.size() > 0) ? src[0] : 8'h00;
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        exp_w = {sb[3], sb[2], sb[1], sb[0]};
        repeat (4) void'(sb.pop_front());
        check("rnd_data", 64'(out_data), 64'(exp_w));
        check("rnd_keep", 64'(out_keep), 64'hF);
        words++;
      end
      @(posedge clk);
      if (in_fire) void'(src.pop_front());
      #1;
    end
    in_valid = 1'b0;
    check("rnd_words", 64'(words), 64'd16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
